// File: rtl/mem_ctrl_pkg.sv
// Shared sizing, state encoding and request types for the masked 1R1W memory controller.
package mem_ctrl_pkg;

   localparam int unsigned DEPTH  = 48;
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned DATA_W = 64;
   localparam int unsigned MASK_W = 8;

   typedef enum logic {StInit, StRun} ctrl_state_e;
   typedef enum logic {ReqA, ReqB} req_sel_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } wr_req_t;

endpackage

// File: rtl/mem_1r1w_masked_ctrl_if.sv
// Core-side bundle: two masked-write requesters, one read requester and the read response.
interface mem_1r1w_masked_ctrl_if;
   import mem_ctrl_pkg::*;

   logic              wa_valid;
   logic              wa_ready;
   logic [ADDR_W-1:0] wa_addr;
   logic [DATA_W-1:0] wa_data;
   logic [MASK_W-1:0] wa_mask;

   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [MASK_W-1:0] wb_mask;

   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output wa_valid, wa_addr, wa_data, wa_mask,
      input  wa_ready,
      output wb_valid, wb_addr, wb_data, wb_mask,
      input  wb_ready,
      output rd_valid, rd_addr,
      input  rd_ready,
      input  rsp_valid, rsp_data,
      output rsp_ready
   );

   modport slave (
      input  wa_valid, wa_addr, wa_data, wa_mask,
      output wa_ready,
      input  wb_valid, wb_addr, wb_data, wb_mask,
      output wb_ready,
      input  rd_valid, rd_addr,
      output rd_ready,
      output rsp_valid, rsp_data,
      input  rsp_ready
   );

endinterface

// File: rtl/mem_rsp_fifo2.sv
// Two-entry valid/ready FIFO holding read responses until the core accepts them.
module mem_rsp_fifo2 #(
   parameter int unsigned DataW = 64
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [DataW-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [DataW-1:0] head,
   output logic [1:0]       count
);

   logic [DataW-1:0] entry_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         entry_q[0] <= '0;
         entry_q[1] <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         if (push) begin
            entry_q[wr_ptr_q] <= push_data;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign valid = (count_q != 2'd0);
   assign head  = entry_q[rd_ptr_q];
   assign count = count_q;

   // Upstream credit check must keep pushes away from a full FIFO.
   assert property (@(posedge clock) disable iff (!reset_n) !(push && (count_q == 2'd2)));

endmodule

// File: rtl/mem_1r1w_masked_ctrl.sv
// Front-end for the 48x64 masked 1R1W macro: zeroing sweep, round-robin write arbitration
// between two requesters, and a read path returning data through a 2-entry response FIFO.
module mem_1r1w_masked_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset_n,
   output logic                 init_done,
   mem_1r1w_masked_ctrl_if.slave bus,
   output logic [ADDR_W-1:0]    mem_R0_addr,
   output logic                 mem_R0_en,
   input  logic [DATA_W-1:0]    mem_R0_data,
   output logic [ADDR_W-1:0]    mem_W0_addr,
   output logic                 mem_W0_en,
   output logic [DATA_W-1:0]    mem_W0_data,
   output logic [MASK_W-1:0]    mem_W0_mask
);

   ctrl_state_e       state_q;
   logic [ADDR_W-1:0] init_cnt_q;
   logic [ADDR_W-1:0] init_addr_q;
   logic              init_wen_q;
   logic              init_done_q;
   req_sel_e          rr_q;
   logic              rd_inflight_q;

   wr_req_t req_a;
   wr_req_t req_b;
   wr_req_t win;
   logic    grant_a;
   logic    grant_b;
   logic    w_hs;
   logic    rd_hs;
   logic    same_addr;
   logic    fifo_pop;
   logic [1:0] fifo_count;

   assign req_a = '{addr: bus.wa_addr, data: bus.wa_data, mask: bus.wa_mask};
   assign req_b = '{addr: bus.wb_addr, data: bus.wb_data, mask: bus.wb_mask};

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (init_done_q) begin
         if (bus.wa_valid && bus.wb_valid) begin
            grant_a = (rr_q == ReqA);
            grant_b = (rr_q == ReqB);
         end else begin
            grant_a = bus.wa_valid;
            grant_b = bus.wb_valid;
         end
      end
   end

   assign w_hs        = grant_a | grant_b;
   assign win         = grant_b ? req_b : req_a;
   assign bus.wa_ready = grant_a;
   assign bus.wb_ready = grant_b;

   // Stall a read that would hit the row being written in the same cycle.
   assign same_addr    = w_hs && (win.addr == bus.rd_addr);
   assign bus.rd_ready = init_done_q && !same_addr &&
                         (({1'b0, fifo_count} + {2'b00, rd_inflight_q}) < 3'd2);
   assign rd_hs        = bus.rd_valid && bus.rd_ready;

   always_comb begin
      mem_W0_en   = init_wen_q | w_hs;
      mem_W0_addr = w_hs ? win.addr : init_addr_q;
      mem_W0_data = w_hs ? win.data : '0;
      mem_W0_mask = w_hs ? win.mask : {MASK_W{init_wen_q}};
      mem_R0_en   = rd_hs;
      mem_R0_addr = rd_hs ? bus.rd_addr : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StInit;
         init_cnt_q    <= '0;
         init_addr_q   <= '0;
         init_wen_q    <= 1'b0;
         init_done_q   <= 1'b0;
         rr_q          <= ReqA;
         rd_inflight_q <= 1'b0;
      end else begin
         case (state_q)
            StInit: begin
               init_wen_q  <= 1'b1;
               init_addr_q <= init_cnt_q;
               init_cnt_q  <= init_cnt_q + ADDR_W'(1);
               if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               init_wen_q  <= 1'b0;
               init_done_q <= 1'b1;
            end
         endcase
         if (w_hs) begin
            rr_q <= grant_a ? ReqB : ReqA;
         end
         rd_inflight_q <= rd_hs;
      end
   end

   assign init_done = init_done_q;
   assign fifo_pop  = bus.rsp_ready && bus.rsp_valid;

   mem_rsp_fifo2 #(
      .DataW (DATA_W)
   ) u_rsp_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (rd_inflight_q),
      .push_data (mem_R0_data),
      .pop       (fifo_pop),
      .valid     (bus.rsp_valid),
      .head      (bus.rsp_data),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_mem_1r1w_masked_ctrl.sv
// Directed bench for mem_1r1w_masked_ctrl with a behavioural model of the masked 1R1W macro.
module tb_mem_1r1w_masked_ctrl;
   import mem_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic init_done;
   logic [ADDR_W-1:0] mem_R0_addr;
   logic              mem_R0_en;
   logic [DATA_W-1:0] mem_R0_data;
   logic [ADDR_W-1:0] mem_W0_addr;
   logic              mem_W0_en;
   logic [DATA_W-1:0] mem_W0_data;
   logic [MASK_W-1:0] mem_W0_mask;

   logic [DATA_W-1:0] mem_model [64];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   mem_1r1w_masked_ctrl_if bus ();

   mem_1r1w_masked_ctrl u_dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .init_done   (init_done),
      .bus         (bus),
      .mem_R0_addr (mem_R0_addr),
      .mem_R0_en   (mem_R0_en),
      .mem_R0_data (mem_R0_data),
      .mem_W0_addr (mem_W0_addr),
      .mem_W0_en   (mem_W0_en),
      .mem_W0_data (mem_W0_data),
      .mem_W0_mask (mem_W0_mask)
   );

   // Macro model: byte-masked write, registered read, out-of-range reads return 0.
   always_ff @(posedge clock) begin
      if (mem_W0_en) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (mem_W0_mask[b]) mem_model[mem_W0_addr][b*8 +: 8] <= mem_W0_data[b*8 +: 8];
         end
      end
      if (mem_R0_en) begin
         mem_R0_data <= (int'(mem_R0_addr) < DEPTH) ? mem_model[mem_R0_addr] : '0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic write_a(input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
      bus.wa_valid = 1'b1;
      bus.wa_addr  = a;
      bus.wa_data  = d;
      bus.wa_mask  = m;
      #1;
      check("wa_ready_single", 64'(bus.wa_ready), 64'd1);
      cyc();
      bus.wa_valid = 1'b0;
   endtask

   localparam logic [63:0] D10 = 64'h0A0A_0A0A_0A0A_0A0A;
   localparam logic [63:0] D11 = 64'h0B0B_0B0B_0B0B_0B0B;
   localparam logic [63:0] D12 = 64'h0C0C_0C0C_0C0C_0C0C;
   localparam logic [63:0] D9  = 64'h9999_0000_9999_0009;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.wa_valid = 1'b1; bus.wa_addr = 6'd3; bus.wa_data = 64'hAAAA_0000_0000_0003;
      bus.wa_mask  = 8'hFF;
      bus.wb_valid = 1'b1; bus.wb_addr = 6'd4; bus.wb_data = 64'hBBBB_0000_0000_0004;
      bus.wb_mask  = 8'hFF;
      bus.rd_valid = 1'b1; bus.rd_addr = 6'd20;
      bus.rsp_ready = 1'b0;

      // Reset state with all requesters asserting valid.
      repeat (3) cyc();
      check("rst_init_done", 64'(init_done), 64'd0);
      check("rst_w0_en", 64'(mem_W0_en), 64'd0);
      check("rst_r0_en", 64'(mem_R0_en), 64'd0);
      check("rst_wa_ready", 64'(bus.wa_ready), 64'd0);
      check("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_data", bus.rsp_data, 64'd0);

      // Zeroing sweep.
      reset_n = 1'b1;
      #1;
      check("pre_sweep_w0_en", 64'(mem_W0_en), 64'd0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc();
         check("sweep_w0_en", 64'(mem_W0_en), 64'd1);
         check("sweep_w0_addr", 64'(mem_W0_addr), 64'(i));
         check("sweep_w0_data", mem_W0_data, 64'd0);
         check("sweep_w0_mask", 64'(mem_W0_mask), 64'hFF);
         check("sweep_init_done", 64'(init_done), 64'd0);
         check("sweep_wa_ready", 64'(bus.wa_ready), 64'd0);
         check("sweep_wb_ready", 64'(bus.wb_ready), 64'd0);
         check("sweep_rd_ready", 64'(bus.rd_ready), 64'd0);
         if (i == DEPTH - 1) bus.rd_valid = 1'b0;
      end
      cyc();
      check("init_done_rise", 64'(init_done), 64'd1);

      // Round-robin with both writers always valid: A,B,A,B.
      for (int g = 0; g < 4; g++) begin
         check("rr_wa_ready", 64'(bus.wa_ready), (g % 2 == 0) ? 64'd1 : 64'd0);
         check("rr_wb_ready", 64'(bus.wb_ready), (g % 2 == 0) ? 64'd0 : 64'd1);
         check("rr_w0_en", 64'(mem_W0_en), 64'd1);
         check("rr_w0_addr", 64'(mem_W0_addr), (g % 2 == 0) ? 64'd3 : 64'd4);
         cyc();
      end
      bus.wa_valid = 1'b0;
      bus.wb_valid = 1'b0;
      #1;
      check("idle_w0_en", 64'(mem_W0_en), 64'd0);

      // Masked write then read: only the low four bytes land.
      write_a(6'd5, 64'h1122_3344_5566_7788, 8'h0F);
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 6'd5;
      #1;
      check("rd5_ready", 64'(bus.rd_ready), 64'd1);
      check("rd5_r0_en", 64'(mem_R0_en), 64'd1);
      check("rd5_r0_addr", 64'(mem_R0_addr), 64'd5);
      cyc();
      bus.rd_valid = 1'b0;
      check("rd5_lat1_valid", 64'(bus.rsp_valid), 64'd0);
      cyc();
      check("rd5_lat2_valid", 64'(bus.rsp_valid), 64'd1);
      check("rd5_data", bus.rsp_data, 64'h0000_0000_5566_7788);
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;
      check("rd5_popped", 64'(bus.rsp_valid), 64'd0);

      // Backpressure: three reads, two accepted until a pop frees a slot.
      write_a(6'd10, D10, 8'hFF);
      write_a(6'd11, D11, 8'hFF);
      write_a(6'd12, D12, 8'hFF);
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 6'd10;
      #1;
      check("bp_rd1_ready", 64'(bus.rd_ready), 64'd1);
      cyc();
      bus.rd_addr = 6'd11;
      #1;
      check("bp_rd2_ready", 64'(bus.rd_ready), 64'd1);
      cyc();
      bus.rd_addr = 6'd12;
      #1;
      check("bp_rd3_stall_a", 64'(bus.rd_ready), 64'd0);
      cyc();
      check("bp_rd3_stall_b", 64'(bus.rd_ready), 64'd0);
      cyc();
      check("bp_rd3_stall_c", 64'(bus.rd_ready), 64'd0);
      check("bp_head0", bus.rsp_data, D10);
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_full_pop_ready", 64'(bus.rd_ready), 64'd0);
      cyc();
      bus.rsp_ready = 1'b0;
      #1;
      check("bp_rd3_ready", 64'(bus.rd_ready), 64'd1);
      check("bp_head1", bus.rsp_data, D11);
      cyc();
      bus.rd_valid = 1'b0;
      check("bp_head1_hold", bus.rsp_data, D11);
      bus.rsp_ready = 1'b1;
      cyc();
      check("bp_head2_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_head2", bus.rsp_data, D12);
      cyc();
      bus.rsp_ready = 1'b0;
      check("bp_drained", 64'(bus.rsp_valid), 64'd0);

      // Same-address write/read collision stalls the read for one cycle.
      bus.wa_valid = 1'b1;
      bus.wa_addr  = 6'd9;
      bus.wa_data  = D9;
      bus.wa_mask  = 8'hFF;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 6'd9;
      #1;
      check("coll_wa_ready", 64'(bus.wa_ready), 64'd1);
      check("coll_rd_ready", 64'(bus.rd_ready), 64'd0);
      check("coll_r0_en", 64'(mem_R0_en), 64'd0);
      cyc();
      bus.wa_valid = 1'b0;
      #1;
      check("coll_rd_ready_next", 64'(bus.rd_ready), 64'd1);
      cyc();
      bus.rd_valid = 1'b0;
      cyc();
      check("coll_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("coll_rsp_data", bus.rsp_data, D9);

      // Fill the FIFO, then reset mid-operation.
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 6'd5;
      #1;
      check("fill_rd_ready", 64'(bus.rd_ready), 64'd1);
      cyc();
      bus.rd_valid = 1'b0;
      cyc();
      check("fill_full_head", bus.rsp_data, D9);
      #1;
      reset_n = 1'b0;
      #1;
      check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("arst_init_done", 64'(init_done), 64'd0);
      check("arst_w0_en", 64'(mem_W0_en), 64'd0);
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      check("resweep_en0", 64'(mem_W0_en), 64'd1);
      check("resweep_addr0", 64'(mem_W0_addr), 64'd0);
      cyc();
      check("resweep_addr1", 64'(mem_W0_addr), 64'd1);
      for (int k = 0; k < 60 && !init_done; k++) cyc();
      check("resweep_done", 64'(init_done), 64'd1);
      check("resweep_rsp_valid", 64'(bus.rsp_valid), 64'd0);

      // Contents written before the reset are zeroed by the new sweep.
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 6'd5;
      #1;
      check("post_rd_ready", 64'(bus.rd_ready), 64'd1);
      cyc();
      bus.rd_valid = 1'b0;
      cyc();
      check("post_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("post_rsp_data", bus.rsp_data, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
